// File: rtl/tx_os_generator.sv
// Ordered-set generator: emits TS1/TS2/EIOS across up to 16 lanes over a ready/valid handshake.
// Define TX_SKP_INSERT_EN to interleave a SKP ordered set after every SKP_INTERVAL non-SKP sets.
module tx_os_generator #(
  parameter int SKP_INTERVAL = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic [1:0]    i_osType,
  input  logic [10:0]   i_sendCount,
  input  logic [7:0]    i_linkNumber,
  input  logic          i_padLink,
  input  logic          i_padLane,
  input  logic [7:0]    i_rateId,
  input  logic [7:0]    i_trainingCtrl,
  input  logic [4:0]    i_activeLanes,
  input  logic          i_osReady,
  output logic          o_osValid,
  output logic [2047:0] o_osData,
  output logic          o_osSkp,
  output logic          o_busy,
  output logic          o_finish,
  output logic [10:0]   o_sentCount
);

  localparam logic [1:0] OS_TS1  = 2'b00;
  localparam logic [1:0] OS_EIOS = 2'b10;
  localparam logic [1:0] OS_RSVD = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DONE = 2'd2} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [1:0]      r_osType;
  logic [10:0]     r_sendCount;
  logic [7:0]      r_linkNumber;
  logic            r_padLink;
  logic            r_padLane;
  logic [7:0]      r_rateId;
  logic [7:0]      r_trainingCtrl;
  logic [4:0]      r_activeLanes;
  logic            r_osValid;
  logic            r_stopPend;
  logic [10:0]     r_sentCount;
  logic            w_osSkp;
  logic            w_startOk;
  logic            w_accept;
  logic            w_lastOs;
  logic            w_stopReq;
  logic [10:0]     w_sentInc;
  logic [2047:0]   w_osData;
  logic [127:0]    w_lane;

  assign w_startOk = i_start & ~i_stop & (i_osType != OS_RSVD);
  assign w_accept  = r_osValid & i_osReady;
  assign w_sentInc = (r_sentCount == 11'h7FF) ? r_sentCount : r_sentCount + 11'd1;
  assign w_lastOs  = (r_sendCount != 11'd0) & ~w_osSkp & (w_sentInc == r_sendCount);
  assign w_stopReq = i_stop | r_stopPend;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (w_startOk) w_nextState = SEND;
      SEND: begin
        if (w_accept && w_lastOs)       w_nextState = DONE;
        else if (w_accept && w_stopReq) w_nextState = IDLE;
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // A stop seen during a stall is remembered so the held set still goes out once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_osType       <= '0;
      r_sendCount    <= '0;
      r_linkNumber   <= '0;
      r_padLink      <= 1'b0;
      r_padLane      <= 1'b0;
      r_rateId       <= '0;
      r_trainingCtrl <= '0;
      r_activeLanes  <= '0;
      r_osValid      <= 1'b0;
      r_stopPend     <= 1'b0;
      r_sentCount    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_startOk) begin
            r_osType       <= i_osType;
            r_sendCount    <= i_sendCount;
            r_linkNumber   <= i_linkNumber;
            r_padLink      <= i_padLink;
            r_padLane      <= i_padLane;
            r_rateId       <= i_rateId;
            r_trainingCtrl <= i_trainingCtrl;
            r_activeLanes  <= i_activeLanes;
            r_osValid      <= 1'b1;
            r_stopPend     <= 1'b0;
            r_sentCount    <= '0;
          end
        end
        SEND: begin
          if (w_accept) begin
            if (!w_osSkp) r_sentCount <= w_sentInc;
            if (w_lastOs || w_stopReq) begin
              r_osValid  <= 1'b0;
              r_stopPend <= 1'b0;
            end
          end else if (i_stop) begin
            r_stopPend <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TX_SKP_INSERT_EN
  localparam int SKP_CW = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;

  logic [SKP_CW-1:0] r_skpCnt;
  logic              r_osSkp;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_skpCnt <= '0;
      r_osSkp  <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_startOk) begin
        r_skpCnt <= '0;
        r_osSkp  <= 1'b0;
      end
    end else if (r_state == SEND && w_accept) begin
      if (w_lastOs || w_stopReq) begin
        r_osSkp <= 1'b0;
      end else if (r_osSkp) begin
        r_osSkp <= 1'b0;
      end else if (r_skpCnt == SKP_CW'(SKP_INTERVAL - 1)) begin
        r_skpCnt <= '0;
        r_osSkp  <= (r_osType != OS_EIOS);
      end else begin
        r_skpCnt <= r_skpCnt + 1'b1;
      end
    end
  end

  assign w_osSkp = r_osSkp;
`else
  assign w_osSkp = 1'b0;
`endif

  // Payload is rebuilt from captured fields, so it cannot drift during a stall.
  always_comb begin
    w_osData = '0;
    w_lane   = '0;
    for (int lane = 0; lane < 16; lane++) begin
      w_lane       = '0;
      w_lane[7:0]  = 8'hBC;
      if (w_osSkp) begin
        w_lane[31:8] = {3{8'h1C}};
      end else if (r_osType == OS_EIOS) begin
        w_lane[31:8] = {3{8'h7C}};
      end else begin
        w_lane[15:8]  = r_padLink ? 8'hF7 : r_linkNumber;
        w_lane[23:16] = r_padLane ? 8'hF7 : 8'(lane);
        w_lane[31:24] = 8'hFF;
        w_lane[39:32] = r_rateId;
        w_lane[47:40] = r_trainingCtrl;
        for (int k = 6; k < 16; k++) begin
          w_lane[k*8 +: 8] = (r_osType == OS_TS1) ? 8'h4A : 8'h45;
        end
      end
      if (5'(lane) < r_activeLanes) w_osData[lane*128 +: 128] = w_lane;
    end
  end

  assign o_osValid   = r_osValid;
  assign o_osData    = r_osValid ? w_osData : '0;
  assign o_osSkp     = r_osValid & w_osSkp;
  assign o_busy      = (r_state != IDLE);
  assign o_finish    = (r_state == DONE);
  assign o_sentCount = r_sentCount;

endmodule

// File: doc/tx_os_generator.md
TX_OS_GENERATOR -- requirements
Module: tx_os_generator

Interface
REQ-001 Parameter SKP_INTERVAL, default 8: non-SKP ordered sets (OS) sent between SKP OS insertions.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle command pulse; captures all command fields.
REQ-005 stop  input  1  abort request for continuous or counted sends.
REQ-006 osType  input  2  00 TS1, 01 TS2, 10 EIOS, 11 reserved (start ignored).
REQ-007 sendCount  input  11  OS to send; 0 = continuous until stop.
REQ-008 linkNumber  input  8  link number field; padLink  input  1  force PAD in link field.
REQ-009 padLane  input  1  force PAD in lane field; rateId  input  8  symbol 4; trainingCtrl  input  8  symbol 5.
REQ-010 activeLanes  input  5  lanes 0..activeLanes-1 driven, others zero (valid 1..16).
REQ-011 osReady  input  1  lane/framing layer accepts osData this cycle.
REQ-012 osValid  output  1  osData holds a valid OS.
REQ-013 osData  output  2048  lane i at bits [i*128+127:i*128], symbol k at lane bits [k*8+7:k*8].
REQ-014 osSkp  output  1  current osData is a SKP OS.
REQ-015 busy  output  1  high outside IDLE; finish  output  1  one-cycle completion pulse.
REQ-016 sentCount  output  11  non-SKP OS accepted in current command.

Function
REQ-017 FSM states IDLE, SEND, DONE; IDLE->SEND on start (osType!=11, stop low); SEND->DONE on acceptance of final counted OS; DONE->IDLE next cycle.
REQ-018 start while busy is ignored; start and stop in the same IDLE cycle: stop wins, stays IDLE.
REQ-019 Command fields registered at start; later input changes do not affect the command in progress.
REQ-020 osValid asserted the cycle after start (latency 1).
REQ-021 Acceptance = osValid & osReady in the same cycle; osData and osSkp stable while osValid & !osReady.
REQ-022 TS1/TS2 lane i: sym0 0xBC; sym1 linkNumber or 0xF7 if padLink; sym2 i or 0xF7 if padLane; sym3 N_FTS 0xFF; sym4 rateId; sym5 trainingCtrl; sym6-15 0x4A (TS1) / 0x45 (TS2).
REQ-023 EIOS lane i: sym0 0xBC, sym1-3 0x7C, sym4-15 0x00.
REQ-024 sentCount increments on each accepted non-SKP OS, saturates at 2047, clears on next accepted start.
REQ-025 Counted mode: finish pulses in DONE, exactly one cycle after the acceptance making sentCount == sendCount; osValid low in DONE.
REQ-026 stop in SEND: if osValid & !osReady, hold OS until accepted, then IDLE; otherwise IDLE next cycle; finish never asserted on abort.
REQ-027 Continuous mode (sendCount 0) ends only via stop or reset.
REQ-028 Lanes >= activeLanes drive 128'h0 for every OS type.

Reset
REQ-029 reset low: state IDLE, osValid 0, osSkp 0, busy 0, finish 0, sentCount 0, osData 0, SKP interval counter 0, immediately, independent of clk.
REQ-030 Reset mid-SEND discards the command; no finish after reset release.

Configuration
REQ-031 Macro TX_SKP_INSERT_EN defined: after every SKP_INTERVAL accepted non-SKP OS in SEND, the next OS is SKP (lane: sym0 0xBC, sym1-3 0x1C, sym4-15 0x00, osSkp 1), not counted; interval counter clears at start.
REQ-032 SKP never inserted after the final counted OS, nor during EIOS commands.
REQ-033 TX_SKP_INSERT_EN undefined: no SKP insertion, osSkp tied 0, interval counter absent.

Verification
REQ-034 start TS1, sendCount 16, padLink/padLane 1, osReady 1 -> 16 OS lanes sym1/sym2 0xF7, finish one cycle after 16th, sentCount 16.
REQ-035 start TS2, linkNumber 0x05, activeLanes 4, sendCount 2 -> lanes 0-3 sym1 0x05, sym2 0..3, sym6-15 0x45; lanes 4-15 zero.
REQ-036 Continuous TS1, osReady toggled 1/0, stop mid-stall -> held OS accepted unchanged, then IDLE, no finish.
REQ-037 TX_SKP_INSERT_EN, SKP_INTERVAL 8, sendCount 20 -> SKP after OS 8 and 16, 22 transfers, sentCount 20, finish once.
REQ-038 reset low during SEND at sentCount 5 -> outputs zero immediately; after release, no osValid until new start.
